// File: rtl/debug_capture_pkg.sv
// Shared types for the debug capture controller.
package debug_capture_pkg;

    localparam int unsigned STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE = 3'd0,
        ST_PRE  = 3'd1,
        ST_WAIT = 3'd2,
        ST_POST = 3'd3,
        ST_DONE = 3'd4
    } state_e;

endpackage

// File: rtl/ram_block_sp.sv
// Single-port sample RAM: write has priority, registered read data when re=1.
module ram_block_sp #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 1024,
    localparam int unsigned AWIDTH = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic              re,
    input  logic [AWIDTH-1:0] addr,
    input  logic [WIDTH-1:0]  dat_in,
    output logic [WIDTH-1:0]  dat_out
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] dat_out_q;

    // Contents and read data are intentionally never reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= dat_in;
        end else if (re) begin
            dat_out_q <= mem_q[addr];
        end
    end

    assign dat_out = dat_out_q;

endmodule

// File: rtl/debug_capture_ctrl.sv
// Logic-analyser style capture controller: pre-trigger history, trigger, post fill, readout.
module debug_capture_ctrl
    import debug_capture_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 1024,
    localparam int unsigned AWIDTH = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              arm,
    input  logic              abort,
    input  logic [AWIDTH-1:0] pretrig,
    input  logic [WIDTH-1:0]  din,
    input  logic              din_valid,
    input  logic              trig,
    input  logic              rd_req,
    input  logic [AWIDTH-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data,
    output logic              rd_valid,
    output logic [2:0]        state,
    output logic              done
);

    state_e            state_q, state_d;
    logic [AWIDTH-1:0] pretrig_q, pretrig_d;
    logic [AWIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [AWIDTH-1:0] fill_q, fill_d;
    logic [AWIDTH-1:0] trig_ptr_q, trig_ptr_d;
    logic [AWIDTH-1:0] post_cnt_q, post_cnt_d;
    logic              done_q, done_d;
    logic              rd_valid_q, rd_valid_d;

    logic              ram_we_c;
    logic              ram_re_c;
    logic [AWIDTH-1:0] ram_addr_c;
    logic [AWIDTH-1:0] start_ptr_c;
    logic [AWIDTH-1:0] post_load_c;

    // Oldest stored sample sits pretrig slots before the trigger, modulo DEPTH.
    assign start_ptr_c = trig_ptr_q - pretrig_q;
    assign post_load_c = AWIDTH'(DEPTH - 1) - pretrig_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            pretrig_q  <= '0;
            wr_ptr_q   <= '0;
            fill_q     <= '0;
            trig_ptr_q <= '0;
            post_cnt_q <= '0;
            done_q     <= 1'b0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pretrig_q  <= pretrig_d;
            wr_ptr_q   <= wr_ptr_d;
            fill_q     <= fill_d;
            trig_ptr_q <= trig_ptr_d;
            post_cnt_q <= post_cnt_d;
            done_q     <= done_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pretrig_d  = pretrig_q;
        wr_ptr_d   = wr_ptr_q;
        fill_d     = fill_q;
        trig_ptr_d = trig_ptr_q;
        post_cnt_d = post_cnt_q;
        done_d     = done_q;
        rd_valid_d = 1'b0;
        ram_we_c   = 1'b0;
        ram_re_c   = 1'b0;
        ram_addr_c = wr_ptr_q;

        if (abort) begin
            state_d = ST_IDLE;
            done_d  = 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE, ST_DONE: begin
                    // arm beats a simultaneous read request
                    if (arm) begin
                        pretrig_d = pretrig;
                        wr_ptr_d  = '0;
                        fill_d    = '0;
                        done_d    = 1'b0;
                        state_d   = (pretrig == '0) ? ST_WAIT : ST_PRE;
                    end else if (rd_req) begin
                        ram_re_c   = 1'b1;
                        ram_addr_c = start_ptr_c + rd_addr;
                        rd_valid_d = 1'b1;
                    end
                end
                ST_PRE: begin
                    if (din_valid) begin
                        ram_we_c = 1'b1;
                        wr_ptr_d = wr_ptr_q + AWIDTH'(1);
                        fill_d   = fill_q + AWIDTH'(1);
                        if (fill_d == pretrig_q) begin
                            state_d = ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (din_valid) begin
                        ram_we_c = 1'b1;
                        wr_ptr_d = wr_ptr_q + AWIDTH'(1);
                        if (trig) begin
                            trig_ptr_d = wr_ptr_q;
                            post_cnt_d = post_load_c;
                            if (post_load_c == '0) begin
                                state_d = ST_DONE;
                                done_d  = 1'b1;
                            end else begin
                                state_d = ST_POST;
                            end
                        end
                    end
                end
                ST_POST: begin
                    if (din_valid) begin
                        ram_we_c   = 1'b1;
                        wr_ptr_d   = wr_ptr_q + AWIDTH'(1);
                        post_cnt_d = post_cnt_q - AWIDTH'(1);
                        if (post_cnt_q == AWIDTH'(1)) begin
                            state_d = ST_DONE;
                            done_d  = 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    done_d  = 1'b0;
                end
            endcase
        end
    end

    ram_block_sp #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk     (clk),
        .we      (ram_we_c),
        .re      (ram_re_c),
        .addr    (ram_addr_c),
        .dat_in  (din),
        .dat_out (rd_data)
    );

    assign rd_valid = rd_valid_q;
    assign state    = state_q;
    assign done     = done_q;

endmodule
